fwpayload_wb_mailbox: RTL and testbench

Wishbone slave mailbox sitting inside `user_project_wrapper`, directly downstream of the Caravel management-SoC Wishbone port. It gives firmware on the management core a register-mapped pair of FIFOs to exchange 32-bit words with the payload core: host-to-core (H2C) and core-to-host (C2H). Status and sticky error bits let firmware poll for data and detect misuse.

---
 rtl/fwpayload_mailbox_pkg.sv | 25 ++
 rtl/fwpayload_sync_fifo.sv | 71 +++++++
 rtl/fwpayload_wb_mailbox.sv | 143 ++++++++++++++
 tb/tb_fwpayload_wb_mailbox.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fwpayload_mailbox_pkg.sv
// Register map and bit positions shared by the Wishbone mailbox.
package fwpayload_mailbox_pkg;

    // Register index, taken from wbs_adr_i[3:2]
    localparam logic [1:0] REG_H2C_DATA = 2'd0;
    localparam logic [1:0] REG_C2H_DATA = 2'd1;
    localparam logic [1:0] REG_STATUS   = 2'd2;
    localparam logic [1:0] REG_CTRL     = 2'd3;

    // STATUS bit positions
    localparam int unsigned ST_H2C_EMPTY = 0;
    localparam int unsigned ST_H2C_FULL  = 1;
    localparam int unsigned ST_C2H_EMPTY = 2;
    localparam int unsigned ST_C2H_FULL  = 3;
    localparam int unsigned ST_OVERFLOW  = 4;
    localparam int unsigned ST_UNDERFLOW = 5;
    localparam int unsigned ST_H2C_CNT_LSB = 8;
    localparam int unsigned ST_C2H_CNT_LSB = 16;

    // CTRL bit positions
    localparam int unsigned CTRL_FLUSH_H2C = 0;
    localparam int unsigned CTRL_FLUSH_C2H = 1;
    localparam int unsigned CTRL_CLR_ERR   = 2;

endpackage

// File: rtl/fwpayload_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count and synchronous flush.
module fwpayload_sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           push,
    input  logic [WIDTH-1:0]               push_data,
    input  logic                           pop,
    input  logic                           flush,
    output logic [WIDTH-1:0]               head_data,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           empty,
    output logic                           full
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;

    // Full/empty gating uses the pre-edge occupancy
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Head word is forced to zero while empty so stale data never leaks out
    assign head_data = empty ? '0 : mem[rd_ptr_q];

    // Next occupancy; simultaneous push and pop leave it unchanged
    always_comb begin
        count_d = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage write; contents need no reset because empty masks the head
    always_ff @(posedge clock) begin
        if (do_push && !flush) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    // Pointer and count state; flush overrides any same-edge push or pop
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/fwpayload_wb_mailbox.sv
// Wishbone slave mailbox: H2C and C2H word FIFOs plus status and sticky errors.
module fwpayload_wb_mailbox
    import fwpayload_mailbox_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int unsigned DEPTH     = 8
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        h2c_valid,
    output logic [31:0] h2c_data,
    input  logic        h2c_ready,
    input  logic        c2h_valid,
    input  logic [31:0] c2h_data,
    output logic        c2h_ready
);

    localparam int unsigned CW = $clog2(DEPTH+1);

    logic          ack_q;
    logic [31:0]   dat_q, dat_d;
    logic          overflow_q, underflow_q;

    logic          hit, access;
    logic [1:0]    reg_idx;
    logic          wr_h2c, rd_c2h, wr_ctrl;

    logic          h2c_push, h2c_pop, h2c_flush, h2c_empty, h2c_full;
    logic          c2h_push, c2h_pop, c2h_flush, c2h_empty, c2h_full;
    logic [CW-1:0] h2c_count, c2h_count;
    logic [31:0]   c2h_head;
    logic [31:0]   status;
    logic          set_ovf, set_unf, clr_err;
    logic          unused_bits;

    assign unused_bits = ^{wbs_adr_i[1:0], wbs_sel_i[3:1]};

    // An access is a hit not already being acknowledged; all side effects key off it
    assign hit     = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign access  = hit & ~ack_q;
    assign reg_idx = wbs_adr_i[3:2];

    assign wr_h2c  = access &  wbs_we_i & (reg_idx == REG_H2C_DATA);
    assign rd_c2h  = access & ~wbs_we_i & (reg_idx == REG_C2H_DATA);
    assign wr_ctrl = access &  wbs_we_i & (reg_idx == REG_CTRL) & wbs_sel_i[0];

    assign h2c_push  = wr_h2c & ~h2c_full;
    assign h2c_pop   = h2c_valid & h2c_ready;
    assign h2c_flush = wr_ctrl & wbs_dat_i[CTRL_FLUSH_H2C];
    assign c2h_push  = c2h_valid & c2h_ready;
    assign c2h_pop   = rd_c2h & ~c2h_empty;
    assign c2h_flush = wr_ctrl & wbs_dat_i[CTRL_FLUSH_C2H];

    assign set_ovf = wr_h2c & h2c_full;
    assign set_unf = rd_c2h & c2h_empty;
    assign clr_err = wr_ctrl & wbs_dat_i[CTRL_CLR_ERR];

    assign h2c_valid = ~h2c_empty;
    assign c2h_ready = ~c2h_full;
    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;

    fwpayload_sync_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_h2c_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (h2c_push),
        .push_data (wbs_dat_i),
        .pop       (h2c_pop),
        .flush     (h2c_flush),
        .head_data (h2c_data),
        .count     (h2c_count),
        .empty     (h2c_empty),
        .full      (h2c_full)
    );

    fwpayload_sync_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_c2h_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (c2h_push),
        .push_data (c2h_data),
        .pop       (c2h_pop),
        .flush     (c2h_flush),
        .head_data (c2h_head),
        .count     (c2h_count),
        .empty     (c2h_empty),
        .full      (c2h_full)
    );

    // STATUS snapshot of the pre-edge state
    always_comb begin
        status = '0;
        status[ST_H2C_EMPTY] = h2c_empty;
        status[ST_H2C_FULL]  = h2c_full;
        status[ST_C2H_EMPTY] = c2h_empty;
        status[ST_C2H_FULL]  = c2h_full;
        status[ST_OVERFLOW]  = overflow_q;
        status[ST_UNDERFLOW] = underflow_q;
        status[ST_H2C_CNT_LSB +: 8] = 8'(h2c_count);
        status[ST_C2H_CNT_LSB +: 8] = 8'(c2h_count);
    end

    // Read data for the access being acknowledged; zero at all other times
    always_comb begin
        dat_d = '0;
        if (access && !wbs_we_i) begin
            unique case (reg_idx)
                REG_C2H_DATA: dat_d = c2h_head;
                REG_STATUS:   dat_d = status;
                default:      dat_d = '0;
            endcase
        end
    end

    // Ack, read data and sticky error bits; set beats clear on the same edge
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ack_q       <= 1'b0;
            dat_q       <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            ack_q       <= access;
            dat_q       <= dat_d;
            overflow_q  <= set_ovf | (overflow_q  & ~clr_err);
            underflow_q <= set_unf | (underflow_q & ~clr_err);
        end
    end

endmodule

// File: tb/tb_fwpayload_wb_mailbox.sv
// Directed bench for the Wishbone mailbox with hand-computed expectations.
module tb_fwpayload_wb_mailbox;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clock;
    logic        reset_n;
    logic        wbs_stb_i, wbs_cyc_i, wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i, wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        h2c_valid;
    logic [31:0] h2c_data;
    logic        h2c_ready;
    logic        c2h_valid;
    logic [31:0] c2h_data;
    logic        c2h_ready;

    int checks;
    int failures;

    fwpayload_wb_mailbox #(
        .BASE_ADDR (BASE),
        .DEPTH     (8)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .wbs_stb_i (wbs_stb_i),
        .wbs_cyc_i (wbs_cyc_i),
        .wbs_we_i  (wbs_we_i),
        .wbs_sel_i (wbs_sel_i),
        .wbs_adr_i (wbs_adr_i),
        .wbs_dat_i (wbs_dat_i),
        .wbs_ack_o (wbs_ack_o),
        .wbs_dat_o (wbs_dat_o),
        .h2c_valid (h2c_valid),
        .h2c_data  (h2c_data),
        .h2c_ready (h2c_ready),
        .c2h_valid (c2h_valid),
        .c2h_data  (c2h_data),
        .c2h_ready (c2h_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One Wishbone access; entered and left 1 time unit after a rising edge
    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                           output logic [31:0] rdat);
        bit got;
        got  = 0;
        rdat = '0;
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = we;
        wbs_adr_i = adr;
        wbs_dat_i = wdat;
        for (int i = 0; i < 4 && !got; i++) begin
            @(posedge clock);
            #1;
            if (wbs_ack_o) begin
                got  = 1;
                rdat = wbs_dat_o;
            end
        end
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
        if (!got) check("ack_timeout", 32'd0, 32'd1);
        @(posedge clock);
        #1;
    endtask

    task automatic wb_write(input logic [31:0] adr, input logic [31:0] wdat);
        logic [31:0] dummy;
        wb_xfer(1'b1, adr, wdat, dummy);
    endtask

    task automatic wb_read(input logic [31:0] adr, output logic [31:0] rdat);
        wb_xfer(1'b0, adr, 32'd0, rdat);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    logic [31:0] rd;
    int          ack_seen;

    initial begin
        checks    = 0;
        failures  = 0;
        reset_n   = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_cyc_i = 1'b0;
        wbs_we_i  = 1'b0;
        wbs_sel_i = 4'hF;
        wbs_adr_i = '0;
        wbs_dat_i = '0;
        h2c_ready = 1'b0;
        c2h_valid = 1'b0;
        c2h_data  = '0;

        #12;
        check("rst_ack", {31'd0, wbs_ack_o}, 32'd0);
        check("rst_dat", wbs_dat_o, 32'd0);
        check("rst_h2c_valid", {31'd0, h2c_valid}, 32'd0);
        check("rst_c2h_ready", {31'd0, c2h_ready}, 32'd1);
        check("rst_h2c_data", h2c_data, 32'd0);
        reset_n = 1'b1;
        step();

        wb_read(BASE + 32'h8, rd);
        check("rst_status", rd, 32'h0000_0005);
        check("dat_idle_zero", wbs_dat_o, 32'd0);

        // H2C: two pushes held back by the core, then drained in order
        wb_write(BASE, 32'hDEAD_BEEF);
        wb_write(BASE, 32'h1234_5678);
        wb_read(BASE + 32'h8, rd);
        check("h2c_cnt2", rd, 32'h0000_0204);
        check("h2c_head", h2c_data, 32'hDEAD_BEEF);
        wb_read(BASE, rd);
        check("h2c_data_read_zero", rd, 32'd0);
        h2c_ready = 1'b1;
        check("h2c_word0_valid", {31'd0, h2c_valid}, 32'd1);
        check("h2c_word0", h2c_data, 32'hDEAD_BEEF);
        step();
        check("h2c_word1_valid", {31'd0, h2c_valid}, 32'd1);
        check("h2c_word1", h2c_data, 32'h1234_5678);
        step();
        check("h2c_drained", {31'd0, h2c_valid}, 32'd0);
        h2c_ready = 1'b0;

        // C2H: core fills all 8 entries, firmware drains then underflows
        c2h_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            c2h_data = i;
            step();
        end
        c2h_valid = 1'b0;
        check("c2h_full_ready", {31'd0, c2h_ready}, 32'd0);
        wb_read(BASE + 32'h8, rd);
        check("c2h_full_status", rd, 32'h0008_0009);
        for (int i = 0; i < 8; i++) begin
            wb_read(BASE + 32'h4, rd);
            check($sformatf("c2h_pop%0d", i), rd, i);
        end
        wb_read(BASE + 32'h4, rd);
        check("c2h_underflow_data", rd, 32'd0);
        wb_read(BASE + 32'h8, rd);
        check("underflow_status", rd, 32'h0000_0025);

        // H2C overflow: ninth push dropped, first eight delivered
        for (int i = 0; i < 9; i++) wb_write(BASE, 32'hA000_0000 + i);
        wb_read(BASE + 32'h8, rd);
        check("overflow_status", rd, 32'h0000_0836);
        h2c_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("ovf_word%0d", i), h2c_data, 32'hA000_0000 + i);
            step();
        end
        check("ovf_drained", {31'd0, h2c_valid}, 32'd0);
        h2c_ready = 1'b0;
        wb_write(BASE + 32'hC, 32'h4);
        wb_read(BASE + 32'h8, rd);
        check("clear_errors", rd, 32'h0000_0005);

        // CTRL flush with sel[0] low is ignored, with sel[0] high empties H2C
        wb_write(BASE, 32'h1);
        wb_write(BASE, 32'h2);
        wbs_sel_i = 4'hE;
        wb_write(BASE + 32'hC, 32'h1);
        wb_read(BASE + 32'h8, rd);
        check("flush_sel_off", rd, 32'h0000_0204);
        wbs_sel_i = 4'hF;
        wb_write(BASE + 32'hC, 32'h1);
        wb_read(BASE + 32'h8, rd);
        check("flush_h2c", rd, 32'h0000_0005);
        check("flush_h2c_valid", {31'd0, h2c_valid}, 32'd0);

        // Address miss: never acked, no side effects
        ack_seen = 0;
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = 1'b1;
        wbs_adr_i = BASE + 32'h10;
        wbs_dat_i = 32'h5555_AAAA;
        for (int i = 0; i < 10; i++) begin
            step();
            if (wbs_ack_o) ack_seen++;
        end
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
        step();
        check("miss_no_ack", ack_seen, 32'd0);
        wb_read(BASE + 32'h8, rd);
        check("miss_no_effect", rd, 32'h0000_0005);

        // Held strobe on STATUS: single-cycle ack every other cycle
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_adr_i = BASE + 32'h8;
        for (int i = 0; i < 6; i++) begin
            step();
            check($sformatf("held_ack%0d", i), {31'd0, wbs_ack_o}, (i % 2 == 0) ? 32'd1 : 32'd0);
        end
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        step();

        // Reset between hit and ack with three words in each FIFO
        for (int i = 0; i < 3; i++) wb_write(BASE, 32'hB000_0000 + i);
        c2h_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            c2h_data = 32'hC000_0000 + i;
            step();
        end
        c2h_valid = 1'b0;
        wb_read(BASE + 32'h8, rd);
        check("pre_reset_status", rd, 32'h0003_0300);
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = 1'b1;
        wbs_adr_i = BASE;
        wbs_dat_i = 32'hFFFF_FFFF;
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_h2c_valid", {31'd0, h2c_valid}, 32'd0);
        check("mid_rst_c2h_ready", {31'd0, c2h_ready}, 32'd1);
        step();
        check("mid_rst_ack", {31'd0, wbs_ack_o}, 32'd0);
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
        reset_n   = 1'b1;
        step();
        wb_read(BASE + 32'h8, rd);
        check("post_rst_status", rd, 32'h0000_0005);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
